// File: rtl/router_input_buffer.sv
// router_input_buffer: input FIFO that decodes the head flit's destination into a one-hot request held until granted.
// Optional stall counter output enabled by defining ROUTER_IBUF_STATS_EN.
module router_input_buffer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int PORT_ID = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [3:0]               req,
  input  logic [3:0]               gnt,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count
`ifdef ROUTER_IBUF_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PORT_ID < 0 || PORT_ID > 3) begin : g_bad_cfg
    $error("router_input_buffer: invalid DEPTH or PORT_ID");
  end
  typedef enum logic [1:0] {IDLE, ROUTE, WAIT_GNT} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count_nxt;
  logic [3:0] req_nxt;
  logic push, pop;
  assign in_ready  = count != (AW+1)'(DEPTH);
  assign push      = in_valid && in_ready;
  assign pop       = state == WAIT_GNT && |(req & gnt);
  assign out_valid = pop;
  assign out_data  = mem[rp];
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    case (state)
      IDLE:     state_nxt = count != '0 ? ROUTE : IDLE;
      ROUTE: begin
        req_nxt   = 4'b0001 << out_data[DATA_W-1 -: 2];
        state_nxt = WAIT_GNT;
      end
      WAIT_GNT: if (pop) begin
        req_nxt   = 4'b0000;
        state_nxt = count_nxt != '0 ? ROUTE : IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      count <= count_nxt;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  // Storage is not reset: clearing the pointers and count is what flushes it.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end
`ifdef ROUTER_IBUF_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt <= '0;
    else if (state == WAIT_GNT && !pop && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule
